// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned memory cycles, word-crossing accesses split in two.
// Optional build macro MISALIGN_TRAP_EN: word-crossing accesses are rejected with respErr instead of split.
module load_store_unit #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [addrWidth-1:0] reqAddr,
  input  logic [dataWidth-1:0] reqWdata,
  input  logic [2:0]           memOp,
  output logic                 respValid,
  input  logic                 respReady,
  output logic [dataWidth-1:0] respData,
  output logic                 respErr,
  output logic [addrWidth-1:0] memAddr,
  output logic                 memRe,
  output logic                 memWe,
  output logic [3:0]           memWmask,
  output logic [dataWidth-1:0] memWdata,
  input  logic [dataWidth-1:0] memRdata
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;

  state_t                 state;
  logic                   split_q;
  logic                   write_q;
  logic [addrWidth-1:0]   word_q;
  logic [1:0]             off_q;
  logic [2:0]             op_q;
  logic [dataWidth-1:0]   wide_hi_q;
  logic [3:0]             lanes_hi_q;
  logic [dataWidth-1:0]   lo_q;

  logic [2:0]             req_size;
  logic                   req_legal;
  logic [3:0]             req_mask;
  logic [1:0]             req_off;
  logic                   req_split;
  logic                   req_trap;
  logic                   req_reject;
  logic [7:0]             req_lanes;
  logic [2*dataWidth-1:0] req_wide;
  logic [addrWidth-1:0]   req_word;

  // Aligns the (possibly two-word) read pair to the access offset and extends to full width.
  function automatic logic [dataWidth-1:0] load_extend(input logic [2*dataWidth-1:0] pair,
                                                       input logic [1:0] off,
                                                       input logic [2:0] op);
    logic [2*dataWidth-1:0] sh;
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [dataWidth-1:0] r;
    sh = pair >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (op)
      3'd0:    r = dataWidth'(b);
      3'd1:    r = dataWidth'(h);
      3'd4:    r = {24'b0, sh[7:0]};
      3'd5:    r = {16'b0, sh[15:0]};
      default: r = sh[dataWidth-1:0];
    endcase
    return r;
  endfunction

  always_comb begin
    req_size  = 3'd1;
    req_legal = 1'b1;
    case (memOp)
      3'd0:    req_size = 3'd1;
      3'd1:    req_size = 3'd2;
      3'd2:    req_size = 3'd4;
      3'd4:    req_legal = !reqWrite;
      3'd5:    begin req_size = 3'd2; req_legal = !reqWrite; end
      default: req_legal = 1'b0;
    endcase
    case (req_size)
      3'd1:    req_mask = 4'b0001;
      3'd2:    req_mask = 4'b0011;
      default: req_mask = 4'b1111;
    endcase
  end

  assign req_off   = reqAddr[1:0];
  assign req_split = ({1'b0, req_off} + req_size) > 3'd4;
  assign req_lanes = {4'b0000, req_mask} << req_off;
  assign req_wide  = {{dataWidth{1'b0}}, reqWdata} << {req_off, 3'b000};
  assign req_word  = {reqAddr[addrWidth-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  assign req_trap = req_split;
`else
  assign req_trap = 1'b0;
`endif

  assign req_reject = !req_legal || req_trap;
  assign reqReady   = (state == IDLE) && !rst;

  // Request fields are captured every idle cycle; the accepting edge leaves the live copy.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      word_q     <= req_word;
      off_q      <= req_off;
      op_q       <= memOp;
      wide_hi_q  <= req_wide[2*dataWidth-1:dataWidth];
      lanes_hi_q <= req_lanes[7:4];
    end
    if (state == ACC1) lo_q <= memRdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      split_q   <= 1'b0;
      write_q   <= 1'b0;
      memAddr   <= '0;
      memRe     <= 1'b0;
      memWe     <= 1'b0;
      memWmask  <= 4'b0;
      memWdata  <= '0;
      respValid <= 1'b0;
      respData  <= '0;
      respErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (reqValid) begin
          split_q <= req_split;
          write_q <= reqWrite;
          if (req_reject) begin
            respErr   <= 1'b1;
            respData  <= '0;
            respValid <= 1'b1;
            state     <= RESP;
          end else begin
            memAddr  <= req_word;
            memRe    <= !reqWrite;
            memWe    <= reqWrite;
            memWmask <= reqWrite ? req_lanes[3:0] : 4'b0;
            memWdata <= reqWrite ? req_wide[dataWidth-1:0] : '0;
            state    <= ACC0;
          end
        end
        ACC0: if (split_q) begin
          // Strobes stay high; only address and lanes move to the next word.
          memAddr  <= word_q + addrWidth'(4);
          memWmask <= write_q ? lanes_hi_q : 4'b0;
          memWdata <= write_q ? wide_hi_q : '0;
          state    <= ACC1;
        end else begin
          memRe    <= 1'b0;
          memWe    <= 1'b0;
          memWmask <= 4'b0;
          if (write_q) begin
            respValid <= 1'b1;
            respErr   <= 1'b0;
            respData  <= '0;
            state     <= RESP;
          end else begin
            state <= CAP;
          end
        end
        ACC1: begin
          memRe    <= 1'b0;
          memWe    <= 1'b0;
          memWmask <= 4'b0;
          if (write_q) begin
            respValid <= 1'b1;
            respErr   <= 1'b0;
            respData  <= '0;
            state     <= RESP;
          end else begin
            state <= CAP;
          end
        end
        CAP: begin
          respData  <= load_extend(split_q ? {memRdata, lo_q} : {{dataWidth{1'b0}}, memRdata},
                                   off_q, op_q);
          respErr   <= 1'b0;
          respValid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (respReady) begin
          respValid <= 1'b0;
          respErr   <= 1'b0;
          respData  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference model, per-cycle output compare, directed and random requests.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [2:0]  memOp = '0;
  logic        respValid;
  logic        respReady = 1'b0;
  logic [31:0] respData;
  logic        respErr;
  logic [31:0] memAddr;
  logic        memRe;
  logic        memWe;
  logic [3:0]  memWmask;
  logic [31:0] memWdata;
  logic [31:0] memRdata = '0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqWdata(reqWdata), .memOp(memOp),
    .respValid(respValid), .respReady(respReady), .respData(respData), .respErr(respErr),
    .memAddr(memAddr), .memRe(memRe), .memWe(memWe), .memWmask(memWmask),
    .memWdata(memWdata), .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: 256 words, aliased on address bits [9:2], 1-cycle read latency.
  logic [31:0] mem [0:255];
  logic        preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= $urandom;
      mem[8'h40] <= 32'h8899AABB;
      mem[8'h41] <= 32'h11223344;
    end else if (memWe) begin
      for (int b = 0; b < 4; b++)
        if (memWmask[b]) mem[memAddr[9:2]][8*b +: 8] <= memWdata[8*b +: 8];
    end
    memRdata <= mem[memAddr[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model of the transaction in flight.
  bit          m_active = 1'b0;
  int          acc_base = 0;
  int          m_lat = 0;
  int          m_nops = 0;
  int          m_hold = 0;
  logic        m_write = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_data = '0;
  logic [31:0] op_addr [2];
  logic [3:0]  op_mask [2];
  logic [31:0] op_data [2];
  logic [31:0] last_data = '0;
  logic        last_err = 1'b0;
  int          last_k = 0;

  task automatic model_req(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int          size;
    logic        legal, split, trap;
    logic [31:0] first, a, val;
    logic [63:0] wide;
    size  = (op == 3'd1 || op == 3'd5) ? 2 : (op == 3'd2) ? 4 : 1;
    legal = (op <= 3'd2) || ((op == 3'd4 || op == 3'd5) && !wr);
    first = addr & ~32'h3;
    split = (((addr + 32'(size) - 32'd1) & ~32'h3) != first);
    trap  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap  = split;
`endif
    m_write    = wr;
    m_data     = '0;
    op_mask[0] = '0;
    op_mask[1] = '0;
    op_addr[0] = first;
    op_addr[1] = first + 32'd4;
    wide       = {32'h0, wdata} << (8 * addr[1:0]);
    op_data[0] = wide[31:0];
    op_data[1] = wide[63:32];
    if (!legal || trap) begin
      m_err = 1'b1; m_lat = 1; m_nops = 0;
    end else begin
      m_err  = 1'b0;
      m_nops = split ? 2 : 1;
      if (wr) begin
        m_lat = 1 + m_nops;
        for (int i = 0; i < size; i++) begin
          a = addr + 32'(i);
          if ((a & ~32'h3) == first) op_mask[0][a[1:0]] = 1'b1;
          else                        op_mask[1][a[1:0]] = 1'b1;
        end
      end else begin
        m_lat = 2 + m_nops;
        val = '0;
        for (int i = 0; i < size; i++) begin
          a = addr + 32'(i);
          val = val | (((mem[a[9:2]] >> (8 * a[1:0])) & 32'hFF) << (8 * i));
        end
        if (op == 3'd0 && val[7])  val = val | 32'hFFFFFF00;
        if (op == 3'd1 && val[15]) val = val | 32'hFFFF0000;
        m_data = val;
      end
    end
  endtask

  // Single compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin : cmp
    int   k;
    logic strobe, exp_valid;
    if (rst) begin
      chk("rst_reqReady", 32'(reqReady), 32'd0);
      chk("rst_memRe", 32'(memRe), 32'd0);
      chk("rst_memWe", 32'(memWe), 32'd0);
      chk("rst_respValid", 32'(respValid), 32'd0);
    end else if (!m_active) begin
      chk("idle_reqReady", 32'(reqReady), 32'd1);
      chk("idle_memRe", 32'(memRe), 32'd0);
      chk("idle_memWe", 32'(memWe), 32'd0);
      chk("idle_respValid", 32'(respValid), 32'd0);
    end else begin
      k = cyc - acc_base;
      strobe = !m_err && k >= 1 && k <= m_nops;
      chk("memRe", 32'(memRe), 32'(strobe && !m_write));
      chk("memWe", 32'(memWe), 32'(strobe && m_write));
      if (strobe) begin
        chk("memAddr", memAddr, op_addr[k-1]);
        if (m_write) begin
          chk("memWmask", 32'(memWmask), 32'(op_mask[k-1]));
          chk("memWdata", memWdata, op_data[k-1]);
        end
      end
      chk("reqReady", 32'(reqReady), 32'(k == 0));
      exp_valid = (k >= m_lat);
      chk("respValid", 32'(respValid), 32'(exp_valid));
      if (exp_valid && respValid) begin
        chk("respData", respData, m_data);
        chk("respErr", 32'(respErr), 32'(m_err));
        if (respReady) begin
          last_data = respData;
          last_err  = respErr;
          last_k    = k;
          m_active  = 1'b0;
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    int vcnt;
    @(posedge clk); #1;
    model_req(wr, op, addr, wdata);
    m_hold   = hold;
    acc_base = cyc;
    m_active = 1'b1;
    reqValid = 1'b1; reqWrite = wr; memOp = op; reqAddr = addr; reqWdata = wdata;
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqWrite = 1'($urandom); memOp = 3'($urandom); reqAddr = $urandom; reqWdata = $urandom;
    vcnt = 0;
    for (int c = 0; c < 30 && m_active; c++) begin
      if (respValid) vcnt++;
      respReady = respValid && (vcnt > hold);
      @(posedge clk); #1;
    end
    respReady = 1'b0;
    if (m_active) begin
      n_chk++;
      $display("FAIL timeout: no response handshake within 30 cycles (op %0d addr %h)", op, addr);
      m_active = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  logic [31:0] saved;
  logic [31:0] word_lo;

  initial begin
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_memWmask", 32'(memWmask), 32'h0);
    chk("rst_memWdata", memWdata, 32'h0);
    chk("rst_respData", respData, 32'h0);
    chk("rst_respErr", 32'(respErr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(1'b0, 3'd2, 32'h100, 32'h0, 0);
    chk("lw_100_data", last_data, 32'h8899AABB);
    chk("lw_100_lat", 32'(last_k), 32'd3);
    do_req(1'b0, 3'd0, 32'h103, 32'h0, 0);
    chk("lb_103", last_data, 32'hFFFFFF88);
    do_req(1'b0, 3'd4, 32'h103, 32'h0, 0);
    chk("lbu_103", last_data, 32'h00000088);
    do_req(1'b0, 3'd1, 32'h102, 32'h0, 0);
    chk("lh_102", last_data, 32'hFFFF8899);

    do_req(1'b0, 3'd2, 32'h102, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("lw_102_err", 32'(last_err), 32'd1);
    chk("lw_102_data", last_data, 32'h0);
    chk("lw_102_lat", 32'(last_k), 32'd1);
`else
    chk("lw_102_err", 32'(last_err), 32'd0);
    chk("lw_102_data", last_data, 32'h33448899);
    chk("lw_102_lat", 32'(last_k), 32'd4);
`endif

    do_req(1'b1, 3'd1, 32'h103, 32'h0000CAFE, 0);
`ifdef MISALIGN_TRAP_EN
    chk("sh_103_err", 32'(last_err), 32'd1);
    chk("sh_103_lat", 32'(last_k), 32'd1);
    chk("sh_103_mem0", mem[8'h40], 32'h8899AABB);
    chk("sh_103_mem1", mem[8'h41], 32'h11223344);
    word_lo = 32'h8899AABB;
`else
    chk("sh_103_err", 32'(last_err), 32'd0);
    chk("sh_103_lat", 32'(last_k), 32'd3);
    chk("sh_103_mem0", mem[8'h40], 32'hFE99AABB);
    chk("sh_103_mem1", mem[8'h41], 32'h112233CA);
    word_lo = 32'hFE99AABB;
`endif

    do_req(1'b0, 3'd3, 32'h100, 32'h0, 0);
    chk("op3_err", 32'(last_err), 32'd1);
    chk("op3_data", last_data, 32'h0);
    chk("op3_lat", 32'(last_k), 32'd1);
    do_req(1'b1, 3'd4, 32'h100, 32'hFFFFFFFF, 0);
    chk("sb4_err", 32'(last_err), 32'd1);
    chk("sb4_lat", 32'(last_k), 32'd1);

    do_req(1'b0, 3'd2, 32'h100, 32'h0, 5);
    chk("hold_data", last_data, word_lo);
    chk("hold_k", 32'(last_k), 32'd8);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                       : 32'h100 + $urandom_range(0, 63);
      do_req(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 2));
    end

`ifndef MISALIGN_TRAP_EN
    saved = mem[8'h41];
    @(posedge clk); #1;
    model_req(1'b1, 3'd1, 32'h103, 32'h0000BEEF);
    acc_base = cyc;
    m_active = 1'b1;
    reqValid = 1'b1; reqWrite = 1'b1; memOp = 3'd1; reqAddr = 32'h103; reqWdata = 32'h0000BEEF;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    m_active = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_memWe", 32'(memWe), 32'd0);
    chk("arst_memRe", 32'(memRe), 32'd0);
    chk("arst_reqReady", 32'(reqReady), 32'd0);
    chk("arst_respValid", 32'(respValid), 32'd0);
    chk("arst_memAddr", memAddr, 32'h0);
    chk("arst_memWmask", 32'(memWmask), 32'h0);
    chk("arst_memWdata", memWdata, 32'h0);
    @(posedge clk); #1;
    chk("arst_second_write", mem[8'h41], saved);
    chk("arst_first_write", 32'(mem[8'h40][31:24]), 32'hEF);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_ready_after", 32'(reqReady), 32'd1);
    chk("arst_respData_after", respData, 32'h0);
    do_req(1'b0, 3'd0, 32'h103, 32'h0, 0);
    chk("arst_lb_after", last_data, 32'hFFFFFFEF);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
CPU-side initiator for the data memory port. Accepts one load/store request at a time from the execute stage over a valid/ready handshake. Issues word-aligned read or byte-masked write cycles to a data memory with 1-cycle synchronous read latency, and splits word-crossing accesses into two cycles. Returns aligned, sign- or zero-extended load data, or a store completion, over a valid/ready response channel.

Parameters:
addrWidth, 32, byte address width
dataWidth, 32, data width; only 32 is supported

Ports:
clk  input  1  single clock; every register samples on the rising edge
rst  input  1  asynchronous, active-high reset
reqValid  input  1  request present
reqReady  output  1  request accepted when reqValid && reqReady
reqWrite  input  1  1 = store, 0 = load
reqAddr  input  addrWidth  byte address
reqWdata  input  dataWidth  store data, right-aligned
memOp  input  3  0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU; all other codes are illegal
respValid  output  1  response present
respReady  input  1  response consumed when respValid && respReady
respData  output  dataWidth  extended load data; 0 for stores and errors
respErr  output  1  illegal op (or misaligned access when the trap feature is enabled)
memAddr  output  addrWidth  word-aligned address; bits [1:0] are always 0
memRe  output  1  read strobe
memWe  output  1  write strobe
memWmask  output  4  byte enables
memWdata  output  dataWidth  lane-shifted write data
memRdata  input  dataWidth  data for the address presented in the previous cycle

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0 except reqReady, which becomes 1 once rst deasserts. Any in-flight access is abandoned, and memWe/memRe drop immediately.
- States: IDLE, ACC0, ACC1, CAP, RESP.
- IDLE: reqReady=1. On acceptance at cycle T, latch the request and compute the following:
  - off = addr[1:0]
  - size: 1, 2 or 4
  - split = (off + size > 4)
- Store write data: wide = reqWdata << 8*off (64-bit); lanes = sizeMask << off (8-bit).
- Illegal memOp (also a store with op 4 or 5): go to RESP with respErr=1. respValid=1 at T+1. No memory cycle is issued.
- ACC0 (cycle T+1): drive memAddr = addr & ~3.
  - Load: memRe=1.
  - Store: memWe=1, memWmask = lanes[3:0], memWdata = wide[31:0].
  - Next state: ACC1 if split; otherwise CAP for a load or RESP for a store.
- ACC1 (T+2): drive memAddr = (addr & ~3) + 4, with 32-bit wrap at 0xFFFFFFFC.
  - Load: memRe=1, and capture memRdata as lo.
  - Store: memWe=1, memWmask = lanes[7:4], memWdata = wide[63:32].
  - Next state: CAP for a load, RESP for a store.
- CAP: capture memRdata as hi (split) or lo (unsplit).
  - raw = ({hi, lo} >> 8*off) truncated to size.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU/LW.
  - Go to RESP.
- Memory strobes are asserted only in ACC0/ACC1, and for exactly one cycle each.
- RESP: respValid=1, with respData/respErr registered and held stable until respReady. Return to IDLE the cycle after the handshake. reqReady=0 in every state except IDLE.
- respValid latency from acceptance at T:
  - unsplit store: T+2
  - split store: T+3
  - unsplit load: T+3
  - split load: T+4
  - illegal op: T+1
- Byte accesses never split. LH splits only at off=3. LW splits at any off≠0.
- Once accepted, a request cannot be cancelled except by rst.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: any split access is not issued. It goes straight to RESP with respErr=1 and respData=0, with respValid at T+1. ACC1 is unreachable.
- Undefined: split accesses are performed as two cycles, as described above.

Test Plan:
Preload memory: word 0x100 = 0x8899AABB, word 0x104 = 0x11223344; request accepted at cycle T.
1. LW 0x100 -> single memRe at T+1 with memAddr=0x100; respValid at T+3; respData=0x8899AABB; respErr=0.
2. LB 0x103 -> respData=0xFFFFFF88. LBU 0x103 -> 0x00000088. LH 0x102 -> 0xFFFF8899.
3. LW 0x102 -> memRe at 0x100 (T+1) and at 0x104 (T+2); respData=0x33448899 at T+4. With MISALIGN_TRAP_EN defined: respErr=1 at T+1 and no memRe.
4. SH 0x103, wdata=0x0000CAFE -> write 0x100 with mask 1000, data 0xFE000000; then write 0x104 with mask 0001, data 0x000000CA. Memory afterwards: 0xFE99AABB and 0x112233CA. respValid at T+3.
5. memOp=3 (load), and memOp=4 with reqWrite=1 -> respErr=1, respData=0 at T+1; memRe=memWe=0 throughout.
6. Hold respReady=0 for 5 cycles after respValid -> respData/respValid stable and reqReady=0. Separately, assert rst during ACC1 of a split store -> memWe drops the same cycle, the second write never occurs, and the unit is back in IDLE with all outputs 0.
